// File: rtl/hdmi_axi_pkg.sv
// hdmi_axi_pkg: shared AXI4-Lite response codes and address helpers for the HDMI register file
package hdmi_axi_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  function automatic int addr_lsb(int dw);
    return dw == 64 ? 3 : 2;
  endfunction
endpackage

// File: rtl/hdmi_axi_wstrb_merge.sv
// hdmi_axi_wstrb_merge: byte-lane merge of old register data with write data under WSTRB
module hdmi_axi_wstrb_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   old_data,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0]   merged
);
  for (genvar b = 0; b < DW / 8; b++) begin : g_lane
    assign merged[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_data[b*8 +: 8];
  end
endmodule

// File: rtl/hdmi_axi_regfile.sv
// hdmi_axi_regfile: AXI4-Lite register file with read-only status slots and per-register write strobes
module hdmi_axi_regfile
  import hdmi_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_REGS = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
  output logic [C_NUM_REGS-1:0]                    wr_pulse_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int LSB = addr_lsb(DW);
  localparam int IW = C_S_AXI_ADDR_WIDTH - LSB;
  logic aw_held, w_held, commit, aw_in, aw_ro, ar_in, aw_fire, w_fire, ar_fire;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data, old_data, merged, rd_val;
  logic [DW/8-1:0] w_strb;
  logic [DW-1:0] regs [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] aw_hit, ar_hit, wr_en;
  axi_resp_e wr_resp;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
  assign S_AXI_AWREADY = ~aw_held & ~S_AXI_BVALID;
  assign S_AXI_WREADY = ~w_held & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = ~S_AXI_RVALID;
  assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_fire = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held & w_held;
  always_comb begin
    aw_hit = '0;
    ar_hit = '0;
    old_data = '0;
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      aw_hit[i] = aw_idx == IW'(i);
      ar_hit[i] = ar_idx == IW'(i);
      if (aw_hit[i]) old_data = regs[i];
      if (ar_hit[i]) rd_val = C_RO_MASK[i] ? status_i[i*DW +: DW] : regs[i];
    end
  end
  assign aw_in = |aw_hit;
  assign aw_ro = |(aw_hit & C_RO_MASK);
  assign ar_in = |ar_hit;
  assign wr_resp = !aw_in ? DECERR : aw_ro ? SLVERR : OKAY;
  // an all-zero strobe still commits OKAY but touches nothing, so no pulse
  assign wr_en = (commit && aw_in && !aw_ro && |w_strb) ? aw_hit : '0;
  hdmi_axi_wstrb_merge #(.DW(DW)) u_merge (
    .old_data(old_data),
    .wdata   (w_data),
    .wstrb   (w_strb),
    .merged  (merged)
  );
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= wr_en;
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= wr_resp;
      end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    else for (int i = 0; i < C_NUM_REGS; i++) if (wr_en[i]) regs[i] <= merged;
  // reads sample regs before any same-edge commit lands, returning the old value
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= OKAY;
    end else if (ar_fire) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA <= rd_val;
      S_AXI_RRESP <= ar_in ? OKAY : DECERR;
    end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign regs_o[g*DW +: DW] = regs[g];
  end
endmodule

// File: doc/hdmi_axi_regfile.md
HDMI_AXI_REGFILE -- requirements
Module: hdmi_axi_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width; legal values 32 or 64.
REQ-002 SHALL have parameter C_NUM_REGS, default 16, register count; legal range 1..1024.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width; must be >= clog2(C_NUM_REGS)+ADDR_LSB.
REQ-004 SHALL have parameter C_RO_MASK, default all-zero, C_NUM_REGS bits; bit i=1 makes register i read-only.
REQ-005 SHALL be clocked by one clock, with an asynchronous, active-high reset.
REQ-006 S_AXI_ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-007 S_AXI_ARESET  in  1  asynchronous active-high reset.
REQ-008 S_AXI_AW{ADDR,PROT,VALID}/AWREADY, W{DATA,STRB,VALID}/WREADY, B{RESP,VALID}/BREADY, AR{ADDR,PROT,VALID}/ARREADY, R{DATA,RESP,VALID}/RREADY  AXI4-Lite slave; widths per parameters.
REQ-009 regs_o  out  C_NUM_REGS*C_S_AXI_DATA_WIDTH  current value of every register, flattened, register i at [i*DW +: DW].
REQ-010 status_i  in  C_NUM_REGS*C_S_AXI_DATA_WIDTH  read value for read-only registers.
REQ-011 wr_pulse_o  out  C_NUM_REGS  one-cycle strobe per register on committed write.

Function
REQ-012 ADDR_LSB SHALL be 2 for 32-bit data and 3 for 64-bit data; index = ADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]; lower bits ignored.
REQ-013 AW and W SHALL be accepted independently into one-entry holding buffers: AWREADY = ~aw_held & ~BVALID; WREADY = ~w_held & ~BVALID.
REQ-014 Commit SHALL occur on the edge after both buffers are held: buffers clear, BVALID rises, wr_pulse_o asserts for that one cycle.
REQ-015 AW-before-W, W-before-AW and simultaneous AW/W SHALL all produce exactly one commit.
REQ-016 Writable in-range register: each byte lane with WSTRB=1 SHALL update; BRESP=OKAY (00); wr_pulse_o[i]=1 only if WSTRB!=0.
REQ-017 Read-only register: no update, no pulse, BRESP=SLVERR (10).
REQ-018 Index >= C_NUM_REGS: no update, no pulse, BRESP=DECERR (11).
REQ-019 BVALID SHALL hold until BREADY; AWREADY/WREADY stay low meanwhile; at most one write outstanding.
REQ-020 ARREADY = ~RVALID; on AR handshake edge RDATA, RRESP and RVALID SHALL register together (1-cycle latency).
REQ-021 Read data: RW register -> stored value; RO register -> status_i slice sampled at the handshake edge; out-of-range -> 0 with DECERR; otherwise OKAY.
REQ-022 RVALID and RDATA SHALL hold stable until RREADY; RREADY and a new ARVALID in the same cycle allow back-to-back reads only after RVALID drops.
REQ-023 Read and commit to the same register in the same edge SHALL return the pre-commit value.
REQ-024 AWPROT/ARPROT SHALL be ignored.

Reset
REQ-025 Reset SHALL asynchronously clear all RW registers, regs_o, wr_pulse_o, BVALID, RVALID, RDATA, BRESP, RRESP, both holding buffers, and drive AWREADY=WREADY=ARREADY=1 after release.
REQ-026 Reset mid-transaction SHALL discard any held AW/W without commit; no B or R response is issued for it.

Structure
REQ-027 Package hdmi_axi_pkg SHALL hold the AXI response constants (OKAY, SLVERR, DECERR) and a function returning ADDR_LSB from data width.
REQ-028 One sub-module, hdmi_axi_wstrb_merge (combinational byte-lane merge of old data, WDATA and WSTRB), SHALL be used by the commit path.

Verification
REQ-029 Write 0xDEADBEEF to index 3 with WSTRB=1111, AW three cycles before W -> BRESP=00, regs_o[3]=0xDEADBEEF, wr_pulse_o[3] high for 1 cycle.
REQ-030 Write 0x000000AA to index 3 with WSTRB=0001 -> regs_o[3]=0xDEADBEAA; read index 3 -> RDATA=0xDEADBEAA, RRESP=00, one cycle after AR handshake.
REQ-031 C_RO_MASK bit 5 set, status_i[5]=0x12345678 -> write to index 5 returns SLVERR with no pulse; read returns 0x12345678.
REQ-032 Access at index C_NUM_REGS -> write BRESP=11 with no state change; read RDATA=0 with RRESP=11.
REQ-033 Hold BREADY low 10 cycles after a write -> AWREADY/WREADY stay low and a second AW is accepted only after the B handshake.
REQ-034 Assert reset while AW is held and W is absent -> no BVALID after reset; all registers read 0.
